// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo issue-stage register file.
//
// Contents:
//   TAG_W      - default tag width ({FU type, station index})
//   FU_TYPE_W  - width of the FU-type field (upper tag bits)
//   IDX_W      - width of the station-index field (lower 5 tag bits)
//   TAG_NONE   - tag value meaning "no producer, value is ready"
//   fu_type_e  - functional-unit type encodings
//   make_tag() - builds a tag from an FU type and a station index
package tomasulo_pkg;

    localparam int TAG_W     = 8;
    localparam int IDX_W     = 5;
    localparam int FU_TYPE_W = TAG_W - IDX_W;

    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    // Type 0 is reserved so that a legal tag can never be all zeros.
    typedef enum logic [FU_TYPE_W-1:0] {
        FU_RSVD = 3'd0,
        FU_ALU  = 3'd1,
        FU_MEM  = 3'd2,
        FU_MUL  = 3'd3,
        FU_DIV  = 3'd4,
        FU_JMP  = 3'd5
    } fu_type_e;

    function automatic logic [TAG_W-1:0] make_tag(input fu_type_e fu,
                                                  input logic [IDX_W-1:0] idx);
        return {fu, idx};
    endfunction

endpackage

// File: rtl/rf_cdb_match.sv
// Compares one producer tag against every common data bus.
//
// Ports:
//   tag      in  TAG_W        tag to look up (0 never matches)
//   cdb_tag  in  N_CDB*TAG_W  broadcast tags, bus k at [k*TAG_W +: TAG_W]
//   cdb_data in  N_CDB*XLEN   broadcast values, bus k at [k*XLEN +: XLEN]
//   hit      out 1            some bus carries this tag
//   data     out XLEN         value from the lowest-index matching bus
module rf_cdb_match #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8,
    parameter int N_CDB = 2
) (
    input  logic [TAG_W-1:0]       tag,
    input  logic [N_CDB*TAG_W-1:0] cdb_tag,
    input  logic [N_CDB*XLEN-1:0]  cdb_data,
    output logic                   hit,
    output logic [XLEN-1:0]        data
);
    import tomasulo_pkg::*;

    // Scan from the highest bus down so the lowest index is applied last
    // and therefore wins when several buses carry the same tag.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int k = N_CDB - 1; k >= 0; k--) begin
            if (tag != TAG_W'(TAG_NONE) && cdb_tag[k*TAG_W +: TAG_W] == tag) begin
                hit  = 1'b1;
                data = cdb_data[k*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/tomasulo_regfile.sv
// Architectural register file with register alias table (RAT) for the
// Tomasulo issue stage. Reads return value + producer tag with CDB bypass,
// renames retag destinations, CDB broadcasts write back and clear tags,
// flush drops all pending renames.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   rd_addr_a/b  in          N_ISSUE source addresses per operand
//   rd_data_a/b  out         source values (bypassed from CDB when ready)
//   rd_tag_a/b   out         producer tags, 0 = value ready
//   ren_en/addr/tag in       per-slot destination rename
//   cdb_tag/data in          N_CDB result broadcasts, tag 0 = idle
//   flush        in          clear the whole RAT
//   busy_cnt     out         registered count of registers with a tag
//   Debug_addr   in          committed-value debug read address
//   Debug_regs   out         committed register value, no bypass
module tomasulo_regfile #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int TAG_W   = tomasulo_pkg::TAG_W,
    parameter int N_ISSUE = 2,
    parameter int N_CDB   = 2,
    localparam int AW     = $clog2(NREG),
    localparam int CW     = $clog2(NREG + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_ISSUE*AW-1:0]    rd_addr_a,
    input  logic [N_ISSUE*AW-1:0]    rd_addr_b,
    output logic [N_ISSUE*XLEN-1:0]  rd_data_a,
    output logic [N_ISSUE*XLEN-1:0]  rd_data_b,
    output logic [N_ISSUE*TAG_W-1:0] rd_tag_a,
    output logic [N_ISSUE*TAG_W-1:0] rd_tag_b,
    input  logic [N_ISSUE-1:0]       ren_en,
    input  logic [N_ISSUE*AW-1:0]    ren_addr,
    input  logic [N_ISSUE*TAG_W-1:0] ren_tag,
    input  logic [N_CDB*TAG_W-1:0]   cdb_tag,
    input  logic [N_CDB*XLEN-1:0]    cdb_data,
    input  logic                     flush,
    output logic [CW-1:0]            busy_cnt,
    input  logic [AW-1:0]            Debug_addr,
    output logic [XLEN-1:0]          Debug_regs
);
    import tomasulo_pkg::*;

    localparam int N_RP = 2 * N_ISSUE;   // total read ports (a then b)

    logic [XLEN-1:0]  regs_reg  [NREG];
    logic [XLEN-1:0]  regs_next [NREG];
    logic [TAG_W-1:0] tags_reg  [NREG];
    logic [TAG_W-1:0] tags_next [NREG];
    logic [CW-1:0]    busy_cnt_reg;
    logic [CW-1:0]    busy_cnt_next;

    // Per-register CDB lookup results
    logic             reg_hit      [NREG];
    logic [XLEN-1:0]  reg_cdb_data [NREG];

    // ------------------------------------------------------------------
    // Write-back match: one comparator per register against all buses.
    // Register 0 always holds tag 0, so its comparator never fires.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg_match
            rf_cdb_match #(
                .XLEN  (XLEN),
                .TAG_W (TAG_W),
                .N_CDB (N_CDB)
            ) u_match (
                .tag      (tags_reg[gi]),
                .cdb_tag  (cdb_tag),
                .cdb_data (cdb_data),
                .hit      (reg_hit[gi]),
                .data     (reg_cdb_data[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state: CDB write/clear, then renames (later slot overrides
    // earlier, and any rename overrides the CDB clear), then flush.
    // The CDB data write is independent of rename and flush.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_next[i] = regs_reg[i];
            tags_next[i] = tags_reg[i];
            if (reg_hit[i]) begin
                regs_next[i] = reg_cdb_data[i];
                tags_next[i] = TAG_W'(TAG_NONE);
            end
        end

        if (!flush) begin
            for (int s = 0; s < N_ISSUE; s++) begin
                if (ren_en[s]
                    && ren_addr[s*AW +: AW] != '0
                    && int'(ren_addr[s*AW +: AW]) < NREG
                    && ren_tag[s*TAG_W +: TAG_W] != TAG_W'(TAG_NONE)) begin
                    tags_next[ren_addr[s*AW +: AW]] = ren_tag[s*TAG_W +: TAG_W];
                end
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                tags_next[i] = TAG_W'(TAG_NONE);
            end
        end

        // x0 is hard zero and never renamed
        regs_next[0] = '0;
        tags_next[0] = TAG_W'(TAG_NONE);
    end

    // Popcount over the next-state tags so the registered count lines up
    // with the registered RAT.
    always_comb begin
        busy_cnt_next = '0;
        for (int i = 1; i < NREG; i++) begin
            if (tags_next[i] != TAG_W'(TAG_NONE)) begin
                busy_cnt_next = busy_cnt_next + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
                tags_reg[i] <= '0;
            end
            busy_cnt_reg <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= regs_next[i];
                tags_reg[i] <= tags_next[i];
            end
            busy_cnt_reg <= busy_cnt_next;
        end
    end

    assign busy_cnt = busy_cnt_reg;

    // ------------------------------------------------------------------
    // Read ports. Ports 0..N_ISSUE-1 are the "a" operands, the rest "b".
    // Reads see the pre-rename RAT; a tag currently on a CDB is bypassed
    // and reported ready.
    // ------------------------------------------------------------------
    logic [N_RP*AW-1:0]    rp_addr;
    logic [N_RP*XLEN-1:0]  rp_data;
    logic [N_RP*TAG_W-1:0] rp_tag;

    assign rp_addr = {rd_addr_b, rd_addr_a};

    generate
        for (gi = 0; gi < N_RP; gi++) begin : g_read
            logic [AW-1:0]    addr;
            logic [TAG_W-1:0] cur_tag;
            logic [XLEN-1:0]  cur_data;
            logic             byp_hit;
            logic [XLEN-1:0]  byp_data;

            assign addr     = rp_addr[gi*AW +: AW];
            assign cur_tag  = tags_reg[addr];
            assign cur_data = regs_reg[addr];

            rf_cdb_match #(
                .XLEN  (XLEN),
                .TAG_W (TAG_W),
                .N_CDB (N_CDB)
            ) u_match (
                .tag      (cur_tag),
                .cdb_tag  (cdb_tag),
                .cdb_data (cdb_data),
                .hit      (byp_hit),
                .data     (byp_data)
            );

            assign rp_data[gi*XLEN +: XLEN] = (addr == '0) ? '0
                                            : byp_hit      ? byp_data
                                            :                cur_data;
            assign rp_tag[gi*TAG_W +: TAG_W] = (addr == '0 || byp_hit) ? TAG_W'(TAG_NONE)
                                             :                           cur_tag;
        end
    endgenerate

    assign rd_data_a = rp_data[N_ISSUE*XLEN-1:0];
    assign rd_data_b = rp_data[N_RP*XLEN-1:N_ISSUE*XLEN];
    assign rd_tag_a  = rp_tag[N_ISSUE*TAG_W-1:0];
    assign rd_tag_b  = rp_tag[N_RP*TAG_W-1:N_ISSUE*TAG_W];

    assign Debug_regs = regs_reg[Debug_addr];

endmodule

// File: tb/tb_tomasulo_regfile.sv
// Directed self-checking bench for tomasulo_regfile (default parameters).
module tb_tomasulo_regfile;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int TW   = 8;
    localparam int NI   = 2;
    localparam int NC   = 2;

    logic             clk;
    logic             rst_n;
    logic [NI*AW-1:0] rd_addr_a, rd_addr_b;
    logic [NI*XLEN-1:0] rd_data_a, rd_data_b;
    logic [NI*TW-1:0] rd_tag_a, rd_tag_b;
    logic [NI-1:0]    ren_en;
    logic [NI*AW-1:0] ren_addr;
    logic [NI*TW-1:0] ren_tag;
    logic [NC*TW-1:0] cdb_tag;
    logic [NC*XLEN-1:0] cdb_data;
    logic             flush;
    logic [5:0]       busy_cnt;
    logic [AW-1:0]    Debug_addr;
    logic [XLEN-1:0]  Debug_regs;

    int checks = 0;
    int errors = 0;

    tomasulo_regfile dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .rd_tag_a   (rd_tag_a),
        .rd_tag_b   (rd_tag_b),
        .ren_en     (ren_en),
        .ren_addr   (ren_addr),
        .ren_tag    (ren_tag),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .flush      (flush),
        .busy_cnt   (busy_cnt),
        .Debug_addr (Debug_addr),
        .Debug_regs (Debug_regs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            $display("check %-14s observed=%h expected=%h ok", tag, obs, exp);
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_in();
        ren_en   = '0;
        ren_addr = '0;
        ren_tag  = '0;
        cdb_tag  = '0;
        cdb_data = '0;
        flush    = 1'b0;
    endtask

    task automatic set_ren(input int s, input logic [AW-1:0] a, input logic [TW-1:0] t);
        ren_en[s]           = 1'b1;
        ren_addr[s*AW +: AW] = a;
        ren_tag[s*TW +: TW]  = t;
    endtask

    task automatic set_cdb(input int k, input logic [TW-1:0] t, input logic [XLEN-1:0] d);
        cdb_tag[k*TW +: TW]      = t;
        cdb_data[k*XLEN +: XLEN] = d;
    endtask

    task automatic dbg(input logic [AW-1:0] a, input string tag, input logic [31:0] exp);
        Debug_addr = a;
        settle();
        chk(tag, Debug_regs, exp);
    endtask

    initial begin
        rst_n      = 1'b0;
        rd_addr_a  = '0;
        rd_addr_b  = '0;
        Debug_addr = '0;
        clear_in();

        // ---------------- reset ----------------
        tick();
        tick();
        chk("rst_busy", 32'(busy_cnt), 32'd0);
        chk("rst_rd0_data", rd_data_a[31:0], 32'd0);
        chk("rst_rd0_tag", 32'(rd_tag_a[7:0]), 32'd0);
        dbg(5'd5, "rst_x5", 32'd0);
        #2 rst_n = 1'b1;

        // ---------------- rename x5 -> 0x21, CDB 0x21 ----------------
        set_ren(0, 5'd5, 8'h21);
        rd_addr_a[4:0] = 5'd5;
        settle();
        chk("pre_ren_tag", 32'(rd_tag_a[7:0]), 32'd0);
        tick(); clear_in(); settle();
        chk("ren_x5_tag", 32'(rd_tag_a[7:0]), 32'h21);
        chk("ren_x5_busy", 32'(busy_cnt), 32'd1);
        set_cdb(0, 8'h21, 32'hDEADBEEF);
        dbg(5'd5, "x5_before_wb", 32'd0);
        chk("x5_bypass_d", rd_data_a[31:0], 32'hDEADBEEF);
        chk("x5_bypass_t", 32'(rd_tag_a[7:0]), 32'd0);
        tick(); clear_in(); settle();
        chk("x5_wb", Debug_regs, 32'hDEADBEEF);
        chk("x5_wb_tag", 32'(rd_tag_a[7:0]), 32'd0);
        chk("x5_wb_busy", 32'(busy_cnt), 32'd0);

        // ---------------- x3 bypass via CDB bus 1 ----------------
        set_ren(1, 5'd3, 8'h42);
        tick(); clear_in();
        rd_addr_a[4:0] = 5'd3;
        set_cdb(1, 8'h42, 32'h1234);
        dbg(5'd3, "x3_before_wb", 32'd0);
        chk("x3_bypass_d", rd_data_a[31:0], 32'h1234);
        chk("x3_bypass_t", 32'(rd_tag_a[7:0]), 32'd0);
        chk("x3_busy", 32'(busy_cnt), 32'd1);
        tick(); clear_in(); settle();
        chk("x3_wb", Debug_regs, 32'h1234);
        chk("x3_busy_after", 32'(busy_cnt), 32'd0);

        // ---------------- rename beats CDB clear on x7 ----------------
        set_ren(0, 5'd7, 8'h21);
        tick(); clear_in();
        rd_addr_b[9:5] = 5'd7;
        settle();
        chk("x7_tag", 32'(rd_tag_b[15:8]), 32'h21);
        set_cdb(0, 8'h21, 32'd5);
        set_ren(0, 5'd7, 8'h21);
        settle();
        chk("x7_bypass_d", rd_data_b[63:32], 32'd5);
        chk("x7_bypass_t", 32'(rd_tag_b[15:8]), 32'd0);
        tick(); clear_in(); settle();
        chk("x7_retag", 32'(rd_tag_b[15:8]), 32'h21);
        dbg(5'd7, "x7_data5", 32'd5);
        chk("x7_busy", 32'(busy_cnt), 32'd1);
        set_cdb(0, 8'h21, 32'd9);
        tick(); clear_in(); settle();
        chk("x7_data9", Debug_regs, 32'd9);
        chk("x7_tag_clr", 32'(rd_tag_b[15:8]), 32'd0);
        chk("x7_busy0", 32'(busy_cnt), 32'd0);

        // ---------------- duplicate tag on both buses: bus 0 wins ----------------
        set_ren(0, 5'd6, 8'h30);
        tick(); clear_in();
        rd_addr_a[9:5] = 5'd6;
        set_cdb(0, 8'h30, 32'h11);
        set_cdb(1, 8'h30, 32'h22);
        settle();
        chk("dup_bypass", rd_data_a[63:32], 32'h11);
        tick(); clear_in();
        dbg(5'd6, "dup_wb", 32'h11);

        // ---------------- two slots rename x4, x0 ignored ----------------
        set_ren(0, 5'd4, 8'h22);
        set_ren(1, 5'd4, 8'h63);
        tick(); clear_in();
        rd_addr_a[4:0] = 5'd4;
        settle();
        chk("x4_slot1_wins", 32'(rd_tag_a[7:0]), 32'h63);
        chk("x4_busy", 32'(busy_cnt), 32'd1);
        set_ren(0, 5'd0, 8'h55);
        set_ren(1, 5'd8, 8'h00);
        rd_addr_a[4:0] = 5'd0;
        rd_addr_b[4:0] = 5'd8;
        tick(); clear_in(); settle();
        chk("x0_data", rd_data_a[31:0], 32'd0);
        chk("x0_tag", 32'(rd_tag_a[7:0]), 32'd0);
        chk("x8_tag0_ign", 32'(rd_tag_b[7:0]), 32'd0);
        chk("ign_busy", 32'(busy_cnt), 32'd1);

        // ---------------- eight tagged, then flush + CDB ----------------
        set_ren(0, 5'd1, 8'h23); set_ren(1, 5'd2, 8'h24); tick(); clear_in();
        set_ren(0, 5'd3, 8'h25); set_ren(1, 5'd4, 8'h26); tick(); clear_in();
        set_ren(0, 5'd5, 8'h27); set_ren(1, 5'd6, 8'h28); tick(); clear_in();
        set_ren(0, 5'd7, 8'h29); set_ren(1, 5'd8, 8'h2A); tick(); clear_in();
        rd_addr_a[4:0] = 5'd2;
        settle();
        chk("eight_busy", 32'(busy_cnt), 32'd8);
        chk("x2_tag", 32'(rd_tag_a[7:0]), 32'h24);
        flush = 1'b1;
        set_cdb(0, 8'h24, 32'hAA);
        set_ren(0, 5'd9, 8'h31);
        tick(); clear_in();
        rd_addr_b[4:0] = 5'd9;
        rd_addr_a[9:5] = 5'd6;
        settle();
        chk("flush_busy", 32'(busy_cnt), 32'd0);
        chk("flush_x2_tag", 32'(rd_tag_a[7:0]), 32'd0);
        chk("flush_x9_tag", 32'(rd_tag_b[7:0]), 32'd0);
        chk("flush_x6_d", rd_data_a[63:32], 32'h11);
        chk("flush_x6_t", 32'(rd_tag_a[15:8]), 32'd0);
        dbg(5'd2, "flush_x2", 32'hAA);
        dbg(5'd3, "flush_x3", 32'h1234);
        dbg(5'd5, "flush_x5", 32'hDEADBEEF);
        dbg(5'd7, "flush_x7", 32'd9);

        // ---------------- async reset mid-cycle ----------------
        set_ren(0, 5'd10, 8'h40);
        tick(); clear_in();
        set_ren(0, 5'd11, 8'h41);
        set_cdb(0, 8'h40, 32'h77);
        rd_addr_a[4:0] = 5'd10;
        rd_addr_b[4:0] = 5'd5;
        settle();
        chk("prerst_byp", rd_data_a[31:0], 32'h77);
        chk("prerst_busy", 32'(busy_cnt), 32'd1);
        #1 rst_n = 1'b0;
        settle();
        chk("arst_busy", 32'(busy_cnt), 32'd0);
        chk("arst_x10_d", rd_data_a[31:0], 32'd0);
        chk("arst_x10_t", 32'(rd_tag_a[7:0]), 32'd0);
        chk("arst_x5_d", rd_data_b[31:0], 32'd0);
        tick(); clear_in();
        #2 rst_n = 1'b1;
        tick();
        rd_addr_b[4:0] = 5'd11;
        settle();
        chk("post_x11_tag", 32'(rd_tag_b[7:0]), 32'd0);
        chk("post_busy", 32'(busy_cnt), 32'd0);
        dbg(5'd10, "post_x10", 32'd0);
        dbg(5'd5, "post_x5", 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net: the directed sequence is short, so this never fires on
    // a healthy run.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tomasulo_regfile.md
# tomasulo_regfile

Parametrised architectural register file with Register Alias Table (RAT) for the Tomasulo issue stage.
- Issue reads operand values and producer tags for N_ISSUE instructions per cycle and renames their destinations to reservation-station tags.
- Results return over N_CDB common data buses; matching registers are updated and their tags cleared.
- A synchronous flush drops all pending renames for mispredict or exception recovery.

## Interface
Parameters:
- XLEN, 32, data width.
- NREG, 32, architectural registers; register 0 is hard zero. AW = $clog2(NREG).
- TAG_W, 8, tag width: bits [TAG_W-1:5] are the FU type, [4:0] the station index. Tag 0 means no producer.
- N_ISSUE, 2, issue slots. Each slot has two source read ports and one rename port.
- N_CDB, 2, CDB broadcast ports.

Ports:
- clk, in, 1: clock. All state changes on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- rd_addr_a / rd_addr_b, in, N_ISSUE×AW: source register addresses.
- rd_data_a / rd_data_b, out, N_ISSUE×XLEN: source values.
- rd_tag_a / rd_tag_b, out, N_ISSUE×TAG_W: producer tags; 0 means the value is ready.
- ren_en, in, N_ISSUE: rename strobe per slot.
- ren_addr, in, N_ISSUE×AW: destination register.
- ren_tag, in, N_ISSUE×TAG_W: new producer tag.
- cdb_tag, in, N_CDB×TAG_W: broadcast tag; 0 means idle.
- cdb_data, in, N_CDB×XLEN: broadcast value.
- flush, in, 1: clear the whole RAT.
- busy_cnt, out, $clog2(NREG+1): number of registers with a nonzero tag.
- Debug_addr, in, AW; Debug_regs, out, XLEN: committed register value, with no forwarding.

## Operation
- Reset (rst_n=0): every register = 0, every tag = 0, busy_cnt = 0. All outputs settle to 0 for address 0; for other addresses they reflect the cleared state.
- Read path (combinational), per port:
  - Address 0 gives data 0 and tag 0.
  - Otherwise, if the current tag t≠0 and some cdb_tag[k]==t, the port returns data cdb_data[k] and tag 0. This is CDB bypass.
  - Otherwise the port returns the register value and t.
- Reads see the pre-rename RAT of the same cycle. Intra-group dependencies are resolved by issue logic, not here.
- CDB update, per register i≥1 with tag t≠0 matching cdb_tag[k]:
  - register[i] <= cdb_data[k].
  - tag[i] <= 0, unless renamed this same cycle.
  - Multiple CDBs carrying the same nonzero tag is illegal; the lowest k wins deterministically.
- Rename: ren_en[s] with ren_addr≠0 and ren_tag≠0 sets tag[ren_addr] <= ren_tag. ren_tag==0 or ren_addr==0 is ignored.
- Priority on the same register in one cycle:
  - Rename beats CDB clear: the tag becomes ren_tag, and the data is still written from the CDB.
  - This prevents the self-wait deadlock when consecutive instructions target the same register on the same FU.
  - Among slots, the higher slot index wins (program order).
- Flush: all tags <= 0 and registers keep their committed values.
  - CDB data in the same cycle is still written.
  - Renames in the same cycle are discarded.
- busy_cnt is a registered popcount of nonzero tags, updated each edge from next-state tags.

## Timing
- Read latency: zero cycles (combinational from addresses, RAT, and CDB).
- A CDB write is visible through the register path on the cycle after the edge. In the same cycle it is visible only via bypass.
- A rename is visible on rd_tag from the cycle after the edge.
- rst_n deassertion is synchronised externally. Assertion takes effect immediately, mid-operation included, and discards in-flight renames and CDB writes.
- busy_cnt lags the tag state by zero cycles relative to registered state. It is valid from the first edge after reset.

## Structure
- Shared package tomasulo_pkg:
  - Constants TAG_W, FU_TYPE_W=TAG_W-5, TAG_NONE=0.
  - FU type encodings (ALU, MEM, MUL, DIV, JMP).
  - Function make_tag(fu, idx).
- One sub-module, rf_cdb_match: combinational compare of one tag against all N_CDB buses. Outputs hit and the selected data with lowest-index priority. It is instantiated once per read port and once per register.
- The array and RAT live in tomasulo_regfile. No memory macro; flops only.

## Test plan
- Reset, then rename x5→0x21, then CDB tag 0x21 data 0xDEADBEEF: x5=0xDEADBEEF, tag 0, busy_cnt 1→0.
- x3 tagged 0x42, CDB 0x42 data 0x1234 in the read cycle: rd_data_a=0x1234 and rd_tag_a=0 the same cycle; register x3 updated next cycle.
- x7 tagged 0x21, and in one cycle CDB 0x21 data 5 plus rename x7→0x21: tag[x7]=0x21 and register x7=5. There is no deadlock; the next CDB 0x21 data 9 gives x7=9, tag 0.
- Slots 0 and 1 both rename x4 (0x22, 0x63): tag[x4]=0x63. Renames of x0 are ignored and rd x0 returns 0/0.
- Eight registers tagged, then flush together with CDB 0x24 for x2 data 0xAA: all tags 0, busy_cnt 0, x2=0xAA, other values unchanged.
- rst_n pulled low mid-cycle during a rename plus CDB: outputs clear immediately, and no write survives the next edge.
